mem_stream_reader: RTL and testbench

- Read-side DMA sequencer placed directly in front of the 1K x 16 on-chip memory.
- On a start command it reads LENGTH consecutive words from BASE_ADDR, driving the memory's external-address read port.
- It honours the memory's single-cycle or multi-cycle read timing and buffers the returned words in a small FIFO.
- It streams the words to the downstream compute datapath over a valid/ready interface and marks the last word.

---
 rtl/mem_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_mem_stream_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Read-side DMA sequencer for the 1K x 16 memory: holds each read K cycles, buffers words, streams them out.
// Latency: a word is valid downstream 2 cycles after its read fires; reads stall whenever the FIFO lacks credit.

module mem_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_head_dat,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_push_dat;
        r_wr        <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head_dat = r_mem[r_rd];
  assign o_count    = r_cnt;
endmodule

module mem_stream_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       length,
  input  logic              multi_cycle_mode,
  input  logic [1:0]        cycle_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_use_external_addr,
  output logic              mem_multi_cycle_mode,
  output logic [1:0]        mem_cycle_count,
  input  logic [DATA_W-1:0] mem_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_last_addr;
  logic [10:0]       r_len;
  logic [10:0]       r_issued;
  logic [10:0]       r_accepted;
  logic              r_mode;
  logic [1:0]        r_cc;
  logic              r_holding;
  logic [1:0]        r_hold_cnt;
  logic              r_cap_pend;

  logic              w_accept;
  logic              w_begin;
  logic              w_active;
  logic              w_fire;
  logic              w_last_fire;
  logic              w_pop;
  logic [1:0]        w_k_m1;
  logic [1:0]        w_hold_idx;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW:0]       w_occ;

  assign w_accept   = (r_state == S_IDLE) && start && (length != 11'd0);
  assign w_k_m1     = r_mode ? r_cc : 2'd0;
  assign w_hold_idx = r_holding ? r_hold_cnt : 2'd0;
  // Credit counts buffered words plus the word still in the capture stage.
  assign w_occ      = {1'b0, w_fifo_cnt} + {{CW{1'b0}}, r_cap_pend};
  assign w_begin    = (r_state == S_RUN) && !r_holding && (r_issued < r_len) && (w_occ < DEPTH_L);
  assign w_active   = r_holding || w_begin;
  assign w_fire     = w_active && (w_hold_idx == w_k_m1);
  assign w_last_fire = w_fire && (r_issued == r_len - 11'd1);
  assign w_cur_addr = r_base + ADDR_W'(r_issued);
  assign w_pop      = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last_fire) w_next = S_DRAIN;
      S_DRAIN: if (done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DRAIN) && w_pop && m_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_last_addr <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_mode      <= 1'b0;
      r_cc        <= '0;
      r_holding   <= 1'b0;
      r_hold_cnt  <= '0;
      r_cap_pend  <= 1'b0;
    end else begin
      r_cap_pend <= w_fire;
      if (w_accept) begin
        r_base     <= base_addr;
        r_len      <= length;
        r_mode     <= multi_cycle_mode;
        r_cc       <= cycle_count;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_fire) r_issued <= r_issued + 11'd1;
        if (w_pop)  r_accepted <= r_accepted + 11'd1;
      end
      if (w_active) r_last_addr <= w_cur_addr;
      if (w_fire) begin
        r_holding  <= 1'b0;
        r_hold_cnt <= '0;
      end else if (w_active) begin
        r_holding  <= 1'b1;
        r_hold_cnt <= w_hold_idx + 2'd1;
      end
    end
  end

  mem_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (r_cap_pend),
    .i_push_dat (mem_data),
    .i_pop      (w_pop),
    .o_head_dat (m_data),
    .o_count    (w_fifo_cnt)
  );

  assign mem_rd_en             = w_active;
  assign mem_addr              = w_active ? w_cur_addr : r_last_addr;
  assign mem_use_external_addr = 1'b1;
  assign mem_multi_cycle_mode  = r_mode;
  assign mem_cycle_count       = r_cc;
  assign m_valid               = (w_fifo_cnt != '0);
  assign m_last                = m_valid && (r_accepted == r_len - 11'd1);
endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a behavioural multi-cycle memory model.
module tb_mem_stream_reader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] length = '0;
  logic        multi_cycle_mode = 1'b0;
  logic [1:0]  cycle_count = '0;
  logic        busy, done, mem_rd_en, mem_use_external_addr, mem_multi_cycle_mode;
  logic [9:0]  mem_addr;
  logic [1:0]  mem_cycle_count;
  logic [15:0] mem_data;
  logic        m_valid, m_last;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int out_dat_q[$];
  int out_last_q[$];
  int out_cyc_q[$];

  logic [15:0] mem [1024];
  logic [1:0]  mcnt;

  always #5 clk = ~clk;

  mem_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .multi_cycle_mode(multi_cycle_mode), .cycle_count(cycle_count), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_use_external_addr(mem_use_external_addr),
    .mem_multi_cycle_mode(mem_multi_cycle_mode), .mem_cycle_count(mem_cycle_count),
    .mem_data(mem_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  initial for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 + 16'(i);

  // Memory returns real data only after the full hold; otherwise a poison word.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt <= '0;
      mem_data <= '0;
    end else if (mem_rd_en) begin
      if (mcnt == (mem_multi_cycle_mode ? mem_cycle_count : 2'd0)) begin
        mem_data <= mem[mem_addr];
        mcnt <= '0;
      end else begin
        mem_data <= 16'hDEAD;
        mcnt <= mcnt + 2'd1;
      end
    end else begin
      mem_data <= 16'hDEAD;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) begin rd_addr_q.push_back(int'(mem_addr)); rd_cyc_q.push_back(cyc); end
    if (m_valid && m_ready) begin
      out_dat_q.push_back(int'(m_data)); out_last_q.push_back(int'(m_last)); out_cyc_q.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    rd_addr_q.delete(); rd_cyc_q.delete(); out_dat_q.delete(); out_last_q.delete(); out_cyc_q.delete();
    done_cnt = 0; done_cyc = -1;
  endtask

  task automatic drive_start(input logic [9:0] b, input logic [10:0] l, input logic m, input logic [1:0] c);
    @(negedge clk);
    base_addr = b; length = l; multi_cycle_mode = m; cycle_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    ok = (done_cnt != d0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    total++; if (mem_rd_en !== 1'b0 || mem_addr !== 10'h0) begin bad++; $display("FAIL reset_rd got=%b/%0h want=0/0", mem_rd_en, mem_addr); end
    total++; if (mem_use_external_addr !== 1'b1) begin bad++; $display("FAIL reset_ext got=%b want=1", mem_use_external_addr); end
    total++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 16'h0) begin bad++; $display("FAIL reset_stream got=%b%b/%0h want=00/0", m_valid, m_last, m_data); end
    total++; if (mem_multi_cycle_mode !== 1'b0 || mem_cycle_count !== 2'd0) begin bad++; $display("FAIL reset_mode got=%b/%0d want=0/0", mem_multi_cycle_mode, mem_cycle_count); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok; int first;
    m_ready = 1'b1;
    clear_logs();
    drive_start(10'h010, 11'd4, 1'b0, 2'd0);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    first = (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -100;
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=no_done want=done"); end
    total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL single_rd_count got=%0d want=4", rd_addr_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      total++; if (rd_addr_q[i] != 16 + i || rd_cyc_q[i] != first + i) begin
        bad++; $display("FAIL single_rd[%0d] got=%0h@%0d want=%0h@%0d", i, rd_addr_q[i], rd_cyc_q[i], 16 + i, first + i); end
    end
    total++; if (out_dat_q.size() != 4) begin bad++; $display("FAIL single_out_count got=%0d want=4", out_dat_q.size()); end
    for (int i = 0; i < 4 && i < out_dat_q.size(); i++) begin
      total++; if (out_dat_q[i] != 'hC010 + i || out_last_q[i] != int'(i == 3) || out_cyc_q[i] != first + 2 + i) begin
        bad++; $display("FAIL single_out[%0d] got=%0h/%0d@%0d want=%0h/%0d@%0d", i, out_dat_q[i], out_last_q[i], out_cyc_q[i],
                        'hC010 + i, int'(i == 3), first + 2 + i); end
    end
    total++; if (done_cnt != 1 || out_cyc_q.size() != 4 || done_cyc != out_cyc_q[3]) begin
      bad++; $display("FAIL single_done got=%0d@%0d want=1@last_word", done_cnt, done_cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_multi();
    bit ok; int first;
    m_ready = 1'b1;
    clear_logs();
    drive_start(10'h100, 11'd3, 1'b1, 2'd2);
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    first = (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -100;
    total++; if (!ok) begin bad++; $display("FAIL multi_timeout got=no_done want=done"); end
    total++; if (rd_addr_q.size() != 9) begin bad++; $display("FAIL multi_rd_count got=%0d want=9", rd_addr_q.size()); end
    for (int i = 0; i < 9 && i < rd_addr_q.size(); i++) begin
      total++; if (rd_addr_q[i] != 'h100 + i / 3 || rd_cyc_q[i] != first + i) begin
        bad++; $display("FAIL multi_rd[%0d] got=%0h@%0d want=%0h@%0d", i, rd_addr_q[i], rd_cyc_q[i], 'h100 + i / 3, first + i); end
    end
    total++; if (out_dat_q.size() != 3) begin bad++; $display("FAIL multi_out_count got=%0d want=3", out_dat_q.size()); end
    for (int i = 0; i < 3 && i < out_dat_q.size(); i++) begin
      total++; if (out_dat_q[i] != 'hC100 + i || out_last_q[i] != int'(i == 2) || out_cyc_q[i] != first + 3 * i + 4) begin
        bad++; $display("FAIL multi_out[%0d] got=%0h/%0d@%0d want=%0h/%0d@%0d", i, out_dat_q[i], out_last_q[i], out_cyc_q[i],
                        'hC100 + i, int'(i == 2), first + 3 * i + 4); end
    end
    total++; if (mem_multi_cycle_mode !== 1'b1 || mem_cycle_count !== 2'd2) begin
      bad++; $display("FAIL multi_latched got=%b/%0d want=1/2", mem_multi_cycle_mode, mem_cycle_count); end
  endtask

  task automatic test_backpressure();
    bit ok; logic [15:0] d0;
    m_ready = 1'b0;
    clear_logs();
    drive_start(10'h200, 11'd8, 1'b0, 2'd0);
    repeat (20) @(negedge clk);
    total++; if (rd_addr_q.size() != 4) begin bad++; $display("FAIL bp_stalled_reads got=%0d want=4", rd_addr_q.size()); end
    d0 = m_data;
    @(negedge clk);
    total++; if (m_valid !== 1'b1 || m_data !== 16'hC200 || d0 !== 16'hC200 || m_last !== 1'b0) begin
      bad++; $display("FAIL bp_head got=%b/%0h/%0h/%b want=1/c200/c200/0", m_valid, d0, m_data, m_last); end
    m_ready = 1'b1;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || done_cnt != 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
    total++; if (rd_addr_q.size() != 8) begin bad++; $display("FAIL bp_rd_count got=%0d want=8", rd_addr_q.size()); end
    for (int i = 0; i < 8 && i < rd_addr_q.size(); i++) begin
      total++; if (rd_addr_q[i] != 'h200 + i) begin bad++; $display("FAIL bp_rd[%0d] got=%0h want=%0h", i, rd_addr_q[i], 'h200 + i); end
    end
    total++; if (out_dat_q.size() != 8) begin bad++; $display("FAIL bp_out_count got=%0d want=8", out_dat_q.size()); end
    for (int i = 0; i < 8 && i < out_dat_q.size(); i++) begin
      total++; if (out_dat_q[i] != 'hC200 + i || out_last_q[i] != int'(i == 7)) begin
        bad++; $display("FAIL bp_out[%0d] got=%0h/%0d want=%0h/%0d", i, out_dat_q[i], out_last_q[i], 'hC200 + i, int'(i == 7)); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int ea[4] = '{1022, 1023, 0, 1};
    m_ready = 1'b1;
    clear_logs();
    drive_start(10'd1022, 11'd4, 1'b0, 2'd0);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    total++; if (!ok || rd_addr_q.size() != 4 || out_dat_q.size() != 4) begin
      bad++; $display("FAIL wrap_counts got=%0d/%0d want=4/4", rd_addr_q.size(), out_dat_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size() && i < out_dat_q.size(); i++) begin
      total++; if (rd_addr_q[i] != ea[i] || out_dat_q[i] != 'hC000 + ea[i]) begin
        bad++; $display("FAIL wrap[%0d] got=%0h/%0h want=%0h/%0h", i, rd_addr_q[i], out_dat_q[i], ea[i], 'hC000 + ea[i]); end
    end
  endtask

  task automatic test_ignore();
    bit ok;
    clear_logs();
    drive_start(10'h123, 11'd0, 1'b1, 2'd3);
    repeat (5) @(negedge clk);
    total++; if (rd_addr_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_len got=rd%0d/done%0d/busy%b want=0/0/0", rd_addr_q.size(), done_cnt, busy); end
    total++; if (mem_multi_cycle_mode !== 1'b0 || mem_cycle_count !== 2'd0) begin
      bad++; $display("FAIL zero_len_latch got=%b/%0d want=0/0", mem_multi_cycle_mode, mem_cycle_count); end
    clear_logs();
    drive_start(10'h300, 11'd3, 1'b1, 2'd1);
    repeat (2) @(negedge clk);
    drive_start(10'h000, 11'd5, 1'b0, 2'd0);
    wait_done(200, ok);
    repeat (8) @(negedge clk);
    total++; if (!ok || done_cnt != 1) begin bad++; $display("FAIL busy_start_done got=%0d want=1", done_cnt); end
    total++; if (rd_addr_q.size() != 6) begin bad++; $display("FAIL busy_start_rd_count got=%0d want=6", rd_addr_q.size()); end
    for (int i = 0; i < 6 && i < rd_addr_q.size(); i++) begin
      total++; if (rd_addr_q[i] != 'h300 + i / 2) begin bad++; $display("FAIL busy_start_rd[%0d] got=%0h want=%0h", i, rd_addr_q[i], 'h300 + i / 2); end
    end
    total++; if (out_dat_q.size() != 3 || out_dat_q[2] != 'hC302) begin bad++; $display("FAIL busy_start_out got=%0d words want=3 ending c302", out_dat_q.size()); end
    total++; if (mem_multi_cycle_mode !== 1'b1 || mem_cycle_count !== 2'd1) begin
      bad++; $display("FAIL busy_start_latch got=%b/%0d want=1/1", mem_multi_cycle_mode, mem_cycle_count); end
  endtask

  task automatic test_reset_mid();
    bit ok; int first;
    m_ready = 1'b1;
    clear_logs();
    drive_start(10'h040, 11'd4, 1'b1, 2'd3);
    for (int i = 0; i < 20 && !mem_rd_en; i++) @(negedge clk);
    @(negedge clk);
    total++; if (mem_rd_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_hold got=%b/%b want=1/1", mem_rd_en, busy); end
    reset_n = 1'b0; #1;
    total++; if ({busy, done, mem_rd_en, m_valid, m_last, mem_multi_cycle_mode} !== 6'b0 || mem_addr !== 10'h0 || mem_cycle_count !== 2'd0 || m_data !== 16'h0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b%b/%0h/%0d/%0h want=000000/0/0/0", busy, done, mem_rd_en, m_valid, m_last,
                      mem_multi_cycle_mode, mem_addr, mem_cycle_count, m_data); end
    total++; if (mem_use_external_addr !== 1'b1) begin bad++; $display("FAIL mid_reset_ext got=%b want=1", mem_use_external_addr); end
    @(negedge clk);
    reset_n = 1'b1;
    clear_logs();
    repeat (6) @(negedge clk);
    total++; if (done_cnt != 0 || rd_addr_q.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset_abandon got=done%0d/rd%0d/busy%b want=0/0/0", done_cnt, rd_addr_q.size(), busy); end
    clear_logs();
    drive_start(10'h050, 11'd2, 1'b1, 2'd1);
    wait_done(100, ok);
    repeat (3) @(negedge clk);
    first = (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -100;
    total++; if (!ok || rd_addr_q.size() != 4 || out_dat_q.size() != 2) begin
      bad++; $display("FAIL post_reset_counts got=%0d/%0d want=4/2", rd_addr_q.size(), out_dat_q.size()); end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      total++; if (rd_addr_q[i] != 'h50 + i / 2 || rd_cyc_q[i] != first + i) begin
        bad++; $display("FAIL post_reset_rd[%0d] got=%0h@%0d want=%0h@%0d", i, rd_addr_q[i], rd_cyc_q[i], 'h50 + i / 2, first + i); end
    end
    for (int i = 0; i < 2 && i < out_dat_q.size(); i++) begin
      total++; if (out_dat_q[i] != 'hC050 + i || out_cyc_q[i] != first + 2 * i + 3) begin
        bad++; $display("FAIL post_reset_out[%0d] got=%0h@%0d want=%0h@%0d", i, out_dat_q[i], out_cyc_q[i], 'hC050 + i, first + 2 * i + 3); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_wrap();
    test_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
